key_dispatch: RTL and testbench
===============================

KEY_DISPATCH -- requirements
Module: key_dispatch

Interface
REQ-001 SHALL have parameter KEY_W, default 24, width of a candidate key.
REQ-002 SHALL have parameter NUM_LANES, default 2 (legal 1..8), number of attached crack worker lanes.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  start request, sampled only while rdy=1.
REQ-006 SHALL have port rdy  output  1  high when idle and able to accept en.
REQ-007 SHALL have port low_key  input  KEY_W  first key of search range (inclusive).
REQ-008 SHALL have port high_key  input  KEY_W  last key of search range (inclusive).
REQ-009 SHALL have port key  output  KEY_W  found key, valid when key_valid=1.
REQ-010 SHALL have port key_valid  output  1  last search found a matching key.
REQ-011 SHALL have port keys_tried  output  KEY_W+1  count of worker results received in last search.
REQ-012 SHALL have port w_en  output  NUM_LANES  one-cycle start pulse per lane.
REQ-013 SHALL have port w_key  output  NUM_LANES*KEY_W  key for lane i in bits [i*KEY_W +: KEY_W], held until lane's next issue.
REQ-014 SHALL have port w_rdy  input  NUM_LANES  lane i can accept a key.
REQ-015 SHALL have port w_done  input  NUM_LANES  one-cycle pulse, lane i finished its key.
REQ-016 SHALL have port w_hit  input  NUM_LANES  qualifies w_done: lane i's key decrypted to valid plaintext.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; rdy=1 only in IDLE.
REQ-018 In IDLE, en=1 SHALL latch low_key/high_key, set next_key=low_key (KEY_W+1 bits), clear key_valid, key, keys_tried and enter RUN next cycle; rdy falls that same edge.
REQ-019 en while rdy=0 SHALL be ignored; low_key/high_key changes after the start edge SHALL have no effect.
REQ-020 In RUN, each cycle at most one lane SHALL be issued: lowest index i with w_rdy[i]=1 and busy[i]=0, only if next_key<=high and no hit recorded.
REQ-021 Issue SHALL register w_key[i]=next_key, pulse w_en[i] for exactly one cycle, set busy[i], increment next_key.
REQ-022 next_key SHALL be KEY_W+1 bits so high_key=all-ones terminates without wrap to 0.
REQ-023 w_done[i] SHALL clear busy[i] and increment keys_tried; w_done on a non-busy lane SHALL be ignored.
REQ-024 w_done[i]&w_hit[i] in RUN SHALL record hit key=w_key[i]; simultaneous hits SHALL select the smallest key; a hit SHALL stop further issue and move to DRAIN.
REQ-025 Issue and done on the same lane in one cycle: done applies to old key, lane stays busy with new key.
REQ-026 DRAIN SHALL issue nothing, still count results, ignore later hits, and return to IDLE when busy=0.
REQ-027 RUN with next_key>high and busy=0 and no hit SHALL return to IDLE with key_valid=0.
REQ-028 low_key>high_key SHALL issue no keys and return to IDLE after one RUN cycle with key_valid=0, keys_tried=0.
REQ-029 On return to IDLE, key SHALL equal the hit key (or 0), key_valid=1 iff a hit; both held stable until next accepted en.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, rdy=1, key=0, key_valid=0, keys_tried=0, w_en=0, w_key=0, busy=0, next_key=0.
REQ-031 Reset mid-search SHALL abandon the search; later w_done pulses from abandoned lanes SHALL be ignored (busy=0).
REQ-032 No output SHALL glitch to non-reset values before the first en after reset deassertion.

Verification
REQ-033 NUM_LANES=2, model lanes 20-cycle latency, low=0x000008, high=0x00001F, hit on 0x000011 -> key=0x000011, key_valid=1, rdy=1, no key >0x000012 issued after hit.
REQ-034 low=0xF00008, high=0xF00009, no hit -> exactly 2 issues, key_valid=0, keys_tried=2, rdy=1.
REQ-035 low=high=0xFFFFFF, no hit -> one issue of 0xFFFFFF, no wrap issue of 0x000000, keys_tried=1.
REQ-036 low=0x10, high=0x0F -> w_en never asserted, key_valid=0, rdy back to 1 within 2 cycles.
REQ-037 Lanes 0 and 1 report hits same cycle on 0x21 and 0x20 -> key=0x20; en pulsed while rdy=0 -> ignored.
REQ-038 Assert rst_n=0 mid-RUN, then new search 0x08..0x1F -> all outputs at reset values during reset; stale w_done ignored; second search result correct.

Source files
------------

// File: rtl/key_dispatch.sv
// rtl/key_dispatch.sv - hands out keys from an inclusive range to crack lanes and records the first hit
// The smallest hitting key wins; after a hit, the lanes that are still busy drain before the block goes idle.
module key_dispatch #(
   parameter int KEY_W     = 24,
   parameter int NUM_LANES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   output logic                       rdy,
   input  logic [KEY_W-1:0]           low_key,
   input  logic [KEY_W-1:0]           high_key,
   output logic [KEY_W-1:0]           key,
   output logic                       key_valid,
   output logic [KEY_W:0]             keys_tried,
   output logic [NUM_LANES-1:0]       w_en,
   output logic [NUM_LANES*KEY_W-1:0] w_key,
   input  logic [NUM_LANES-1:0]       w_rdy,
   input  logic [NUM_LANES-1:0]       w_done,
   input  logic [NUM_LANES-1:0]       w_hit
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [KEY_W:0] ONE = {{KEY_W{1'b0}}, 1'b1};

   state_t               state, state_nx;
   logic [KEY_W-1:0]     high_r;
   logic [KEY_W:0]       next_key;
   logic [NUM_LANES-1:0] busy;

   logic [NUM_LANES-1:0] done_v, hit_v, issue_v;
   logic                 hit_any, in_range, found;
   logic [KEY_W-1:0]     hit_key;
   logic [KEY_W:0]       done_cnt;

   // next_key carries an extra bit so a range ending at all-ones stops instead of wrapping
   always_comb begin
      done_v   = w_done & busy;
      hit_v    = (state == RUN) ? (done_v & w_hit) : '0;
      hit_any  = 1'b0;
      hit_key  = '0;
      done_cnt = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (done_v[i])
            done_cnt = done_cnt + ONE;
         if (hit_v[i] && (!hit_any || (w_key[i*KEY_W +: KEY_W] < hit_key))) begin
            hit_any = 1'b1;
            hit_key = w_key[i*KEY_W +: KEY_W];
         end
      end

      in_range = (next_key <= {1'b0, high_r});
      issue_v  = '0;
      found    = 1'b0;
      if ((state == RUN) && in_range && !hit_any) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && w_rdy[i] && !busy[i]) begin
               issue_v[i] = 1'b1;
               found      = 1'b1;
            end
         end
      end

      state_nx = state;
      case (state)
         IDLE:    if (en) state_nx = RUN;
         RUN:     if (hit_any) state_nx = DRAIN;
                  else if (!in_range && (busy == '0)) state_nx = IDLE;
         DRAIN:   if (busy == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign rdy = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         high_r     <= '0;
         next_key   <= '0;
         busy       <= '0;
         w_en       <= '0;
         w_key      <= '0;
         key        <= '0;
         key_valid  <= 1'b0;
         keys_tried <= '0;
      end else begin
         state      <= state_nx;
         w_en       <= issue_v;
         busy       <= (busy & ~done_v) | issue_v;
         keys_tried <= keys_tried + done_cnt;
         if (|issue_v)
            next_key <= next_key + ONE;
         for (int i = 0; i < NUM_LANES; i++)
            if (issue_v[i])
               w_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
         if (hit_any) begin
            key       <= hit_key;
            key_valid <= 1'b1;
         end
         if ((state == IDLE) && en) begin
            high_r     <= high_key;
            next_key   <= {1'b0, low_key};
            key        <= '0;
            key_valid  <= 1'b0;
            keys_tried <= '0;
         end
      end
   end

endmodule

// File: tb/tb_key_dispatch.sv
// tb/tb_key_dispatch.sv - directed bench for key_dispatch with 20-cycle lane models
module tb_key_dispatch;
   localparam int KW  = 24;
   localparam int NL  = 2;
   localparam int LAT = 20;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b0;
   logic            rdy;
   logic [KW-1:0]   low_key = '0;
   logic [KW-1:0]   high_key = '0;
   logic [KW-1:0]   key;
   logic            key_valid;
   logic [KW:0]     keys_tried;
   logic [NL-1:0]   w_en, w_rdy, w_done, w_hit;
   logic [NL*KW-1:0] w_key;

   always #5 clk = ~clk;

   key_dispatch #(.KEY_W(KW), .NUM_LANES(NL)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
      .low_key(low_key), .high_key(high_key),
      .key(key), .key_valid(key_valid), .keys_tried(keys_tried),
      .w_en(w_en), .w_key(w_key), .w_rdy(w_rdy), .w_done(w_done), .w_hit(w_hit)
   );

   logic          manual = 1'b0;
   logic [NL-1:0] man_rdy = '0, man_done = '0, man_hit = '0;
   logic [NL-1:0] m_rdy, m_done = '0, m_hit = '0;
   int            cnt[NL] = '{default: 0};
   int            lsid[NL] = '{default: 0};
   logic [KW-1:0] lkey[NL] = '{default: '0};
   logic          hit_on = 1'b0;
   logic [KW-1:0] hit_key = '0;
   int            search_id = 0;
   int            n_done = 0;

   assign w_rdy  = manual ? man_rdy  : m_rdy;
   assign w_done = manual ? man_done : m_done;
   assign w_hit  = manual ? man_hit  : m_hit;

   always_comb begin
      m_rdy = '0;
      for (int i = 0; i < NL; i++) m_rdy[i] = (cnt[i] == 0);
   end

   // lane model: accept on w_en, pulse done LAT cycles later; lanes ignore DUT reset
   always @(posedge clk) begin
      int inc;
      inc = 0;
      for (int i = 0; i < NL; i++) begin
         m_done[i] <= 1'b0;
         m_hit[i]  <= 1'b0;
         if (cnt[i] != 0) begin
            cnt[i] <= cnt[i] - 1;
            if (cnt[i] == 1) begin
               m_done[i] <= 1'b1;
               m_hit[i]  <= hit_on && (lkey[i] == hit_key);
               if (lsid[i] == search_id) inc = inc + 1;
            end
         end else if (w_en[i]) begin
            cnt[i]  <= LAT;
            lkey[i] <= w_key[i*KW +: KW];
            lsid[i] <= search_id;
         end
      end
      n_done <= n_done + inc;
   end

   int            mon_id = -1;
   int            iss = 0;
   logic [KW-1:0] mx = '0, mn = '1;
   always @(negedge clk) begin
      int t_iss;
      logic [KW-1:0] t_mx, t_mn;
      t_iss = (mon_id != search_id) ? 0 : iss;
      t_mx  = (mon_id != search_id) ? '0 : mx;
      t_mn  = (mon_id != search_id) ? '1 : mn;
      for (int i = 0; i < NL; i++) begin
         if (w_en[i]) begin
            t_iss = t_iss + 1;
            if (w_key[i*KW +: KW] > t_mx) t_mx = w_key[i*KW +: KW];
            if (w_key[i*KW +: KW] < t_mn) t_mn = w_key[i*KW +: KW];
         end
      end
      mon_id <= search_id;
      iss    <= t_iss;
      mx     <= t_mx;
      mn     <= t_mn;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic wait_rdy(input int budget);
      int c;
      c = 0;
      while (!rdy && c < budget) begin @(negedge clk); c++; end
      check("rdy_wait", rdy, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"}, rdy, 1);
      check({tag, "_key"}, key, 0);
      check({tag, "_valid"}, key_valid, 0);
      check({tag, "_tried"}, keys_tried, 0);
      check({tag, "_w_en"}, w_en, 0);
      check({tag, "_w_key"}, w_key, 0);
   endtask

   // returns edges from the start edge until rdy is seen again
   task automatic run_search(input logic [KW-1:0] lo, input logic [KW-1:0] hi, output int cyc);
      wait_rdy(200);
      search_id++;
      @(negedge clk);
      low_key = lo; high_key = hi; en = 1'b1;
      @(negedge clk);
      en = 1'b0; low_key = ~lo; high_key = ~hi;
      cyc = 1;
      while (!rdy && cyc < 3000) begin @(negedge clk); cyc++; end
      check("search_done", rdy, 1);
   endtask

   typedef struct {
      logic [KW-1:0] lo, hi;
      logic          hon;
      logic [KW-1:0] hk;
      logic          exp_valid;
      logic [KW-1:0] exp_key;
      int            iss_lo, iss_hi;
      logic [KW-1:0] max_lim, exp_min;
      int            max_cyc;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int cyc, snap;
      vecs[0] = '{24'h000008, 24'h00001F, 1'b1, 24'h000011, 1'b1, 24'h000011, 10, 11, 24'h000012, 24'h000008, 3000};
      vecs[1] = '{24'hF00008, 24'hF00009, 1'b0, 24'h000000, 1'b0, 24'h000000,  2,  2, 24'hF00009, 24'hF00008, 3000};
      vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'h000000, 1'b0, 24'h000000,  1,  1, 24'hFFFFFF, 24'hFFFFFF, 3000};
      vecs[3] = '{24'h000010, 24'h00000F, 1'b0, 24'h000000, 1'b0, 24'h000000,  0,  0, 24'h000000, 24'hFFFFFF, 2};

      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset_outputs("post_reset");
      end

      for (int v = 0; v < 4; v++) begin
         hit_on = vecs[v].hon; hit_key = vecs[v].hk;
         snap = n_done;
         run_search(vecs[v].lo, vecs[v].hi, cyc);
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_valid", v), key_valid, vecs[v].exp_valid);
         check($sformatf("v%0d_key", v), key, vecs[v].exp_key);
         check($sformatf("v%0d_rdy", v), rdy, 1);
         check_range($sformatf("v%0d_issues", v), iss, vecs[v].iss_lo, vecs[v].iss_hi);
         check_range($sformatf("v%0d_tried", v), keys_tried, vecs[v].iss_lo, vecs[v].iss_hi);
         check($sformatf("v%0d_tried_model", v), keys_tried, n_done - snap);
         check_range($sformatf("v%0d_max_key", v), mx, 0, vecs[v].max_lim);
         check($sformatf("v%0d_min_key", v), mn, vecs[v].exp_min);
         check_range($sformatf("v%0d_latency", v), cyc, 1, vecs[v].max_cyc);
      end

      // simultaneous hits: lane 1 holds 0x20, lane 0 holds 0x21
      manual = 1'b1; man_rdy = 2'b10; hit_on = 1'b0;
      wait_rdy(200);
      search_id++;
      @(negedge clk);
      low_key = 24'h20; high_key = 24'h2F; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("sim_issue1_en", w_en, 2'b10);
      check("sim_issue1_key", w_key[KW +: KW], 24'h20);
      man_rdy = 2'b01;
      @(negedge clk);
      check("sim_issue2_en", w_en, 2'b01);
      check("sim_issue2_key", w_key[0 +: KW], 24'h21);
      man_rdy = 2'b00;
      en = 1'b1; low_key = 24'h0; high_key = 24'h0;
      @(negedge clk);
      en = 1'b0;
      check("sim_busy_rdy", rdy, 0);
      check("sim_no_reissue", w_en, 0);
      man_done = 2'b11; man_hit = 2'b11;
      @(negedge clk);
      man_done = 2'b00; man_hit = 2'b00;
      wait_rdy(5);
      check("sim_key", key, 24'h20);
      check("sim_valid", key_valid, 1);
      check("sim_tried", keys_tried, 2);
      repeat (4) @(negedge clk);
      check("sim_key_hold", key, 24'h20);
      check("sim_w_key_hold", w_key, {24'h20, 24'h21});
      check("sim_ignored_en_issues", iss, 2);

      // reset mid-run with lanes still busy, then a fresh search
      manual = 1'b0; hit_on = 1'b1; hit_key = 24'h11;
      repeat (LAT + 4) @(negedge clk);
      wait_rdy(200);
      search_id++;
      @(negedge clk);
      low_key = 24'h08; high_key = 24'h1F; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_run_busy", rdy, 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      check_reset_outputs("mid_reset_hold");
      rst_n = 1'b1;
      snap = n_done;
      run_search(24'h08, 24'h1F, cyc);
      check("rerun_key", key, 24'h11);
      check("rerun_valid", key_valid, 1);
      check("rerun_tried_model", keys_tried, n_done - snap);
      check_range("rerun_tried", keys_tried, 10, 11);
      check("rerun_min_key", mn, 24'h08);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "watchdog");
   end

endmodule
